// File: rtl/bingo_pkg.sv
// Shared definitions for the bingo number draw path: sizes, FSM encoding and
// the 8-bit LFSR step function.
package bingo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int MAX_NUMBER = 90;

    // Taps for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_PROBE = 2'd2,
        ST_EMIT  = 2'd3
    } draw_state_e;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        if (v == 8'h00) begin
            return 8'h01;
        end
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/number_draw_unit_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; escapes the all-zero lock-up state and
// never loads zero from reset.
module lfsr8
    import bingo_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    localparam logic [7:0] RESET_VAL = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= lfsr_next(q_q);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/number_draw_unit.sv
// Draws never-repeating bingo numbers in 1..MAX_NUMBER: an LFSR picks a start
// point, then a linear probe with wrap finds the next undrawn number.
module number_draw_unit #(
    parameter int         DATA_WIDTH = bingo_pkg::DATA_WIDTH,
    parameter int         MAX_NUMBER = bingo_pkg::MAX_NUMBER,
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    parameter int         CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_game,
    input  logic                  draw_req,
    input  logic                  halt,
    output logic [DATA_WIDTH-1:0] guessed_number,
    output logic                  next_edge,
    output logic                  busy,
    output logic                  exhausted,
    output logic [CNT_WIDTH-1:0]  draw_count
);

    import bingo_pkg::*;

    draw_state_e           state_q;
    logic [7:0]            lfsr_q;
    logic [MAX_NUMBER:1]   used_q;
    logic [DATA_WIDTH-1:0] cand_q;
    logic [DATA_WIDTH-1:0] guessed_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  exhausted_q;
    logic                  next_edge_q;
    logic                  busy_q;
    logic                  req_prev_q;

    logic                  req_edge;
    logic                  lfsr_in_range;
    logic                  cand_free;
    logic [MAX_NUMBER:1]   used_d;
    logic [DATA_WIDTH-1:0] cand_d;
    logic [CNT_WIDTH-1:0]  count_d;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign req_edge      = draw_req & ~req_prev_q;
    assign lfsr_in_range = (int'(lfsr_q) >= 1) && (int'(lfsr_q) <= MAX_NUMBER);
    assign cand_d        = (cand_q == DATA_WIDTH'(MAX_NUMBER)) ? DATA_WIDTH'(1)
                                                               : cand_q + DATA_WIDTH'(1);
    assign count_d       = count_q + CNT_WIDTH'(1);

    // Bitmap lookup and update for the current candidate; bit 0 never exists.
    always_comb begin
        cand_free = 1'b0;
        used_d    = used_q;
        for (int i = 1; i <= MAX_NUMBER; i++) begin
            if (cand_q == DATA_WIDTH'(i)) begin
                cand_free = ~used_q[i];
                used_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev_q <= 1'b0;
        end else begin
            req_prev_q <= draw_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            used_q      <= '0;
            cand_q      <= '0;
            guessed_q   <= '0;
            count_q     <= '0;
            exhausted_q <= 1'b0;
            next_edge_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (new_game) begin
            // Aborts any draw in flight; the last shown number stays visible.
            state_q     <= ST_IDLE;
            used_q      <= '0;
            count_q     <= '0;
            exhausted_q <= 1'b0;
            next_edge_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    next_edge_q <= 1'b0;
                    if (req_edge && !halt && !exhausted_q) begin
                        state_q <= ST_SEED;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SEED: begin
                    if (lfsr_in_range) begin
                        cand_q  <= DATA_WIDTH'(lfsr_q);
                        state_q <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    if (cand_free) begin
                        used_q      <= used_d;
                        guessed_q   <= cand_q;
                        count_q     <= count_d;
                        exhausted_q <= (count_d == CNT_WIDTH'(MAX_NUMBER));
                        next_edge_q <= 1'b1;
                        state_q     <= ST_EMIT;
                    end else begin
                        cand_q <= cand_d;
                    end
                end
                ST_EMIT: begin
                    next_edge_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    next_edge_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign guessed_number = guessed_q;
    assign next_edge      = next_edge_q;
    assign busy           = busy_q;
    assign exhausted      = exhausted_q;
    assign draw_count     = count_q;

endmodule

// File: tb/tb_number_draw_unit.sv
// Directed bench for number_draw_unit configured with MAX_NUMBER=4; a small
// LFSR model lets each request be timed so the draw start point is known.
module tb_number_draw_unit;

    localparam int         MAXN   = 4;
    localparam logic [7:0] SEED_C = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       draw_req = 1'b0;
    logic       halt = 1'b0;
    logic [7:0] guessed_number;
    logic       next_edge;
    logic       busy;
    logic       exhausted;
    logic [6:0] draw_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] lfsr_m;
    bit         used_m [5];

    number_draw_unit #(
        .DATA_WIDTH (8),
        .MAX_NUMBER (MAXN),
        .LFSR_SEED  (SEED_C),
        .CNT_WIDTH  (7)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .new_game       (new_game),
        .draw_req       (draw_req),
        .halt           (halt),
        .guessed_number (guessed_number),
        .next_edge      (next_edge),
        .busy           (busy),
        .exhausted      (exhausted),
        .draw_count     (draw_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] v);
        if (v == 8'd0) return 8'd1;
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= SEED_C;
        else     lfsr_m <= step(lfsr_m);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 5; i++) used_m[i] = 1'b0;
    endtask

    // Raise draw_req so the LFSR value seen in the SEED cycle equals target.
    task automatic arm(input string tag, input logic [7:0] target);
        bit ok;
        ok = 1'b0;
        draw_req = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 600; t++) begin
            if (step(lfsr_m) == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_arm"}, 32'(ok), 32'd1);
        draw_req = 1'b1;
    endtask

    // Follow one draw from the request edge; returns number and cycles SEED->EMIT.
    task automatic run_draw(input string tag, input bit halt_mid,
                            output int num, output int lat);
        int         k, j, cand;
        logic [7:0] v;
        bit         seen;
        @(posedge clk); #1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        v = lfsr_m;
        k = 0;
        while (!(v >= 8'd1 && v <= 8'(MAXN)) && k < 300) begin
            v = step(v);
            k++;
        end
        cand = int'(v);
        j = 0;
        while (used_m[cand] && j <= MAXN) begin
            cand = (cand == MAXN) ? 1 : cand + 1;
            j++;
        end
        if (halt_mid) halt = 1'b1;
        seen = 1'b0;
        lat = 0;
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk); #1;
            if (next_edge) begin
                seen = 1'b1;
                lat = n;
                break;
            end
        end
        num = int'(guessed_number);
        check({tag, "_strobe"}, 32'(seen), 32'd1);
        check({tag, "_num"}, 32'(num), 32'(cand));
        check({tag, "_lat"}, 32'(lat), 32'(2 + k + j));
        used_m[cand] = 1'b1;
        @(posedge clk); #1;
        check({tag, "_strobe_len"}, 32'(next_edge), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int num, lat, strobes, busies;
        clear_model();

        // Reset values, then a quiet idle period
        #12;
        check("rst_guess", 32'(guessed_number), 32'd0);
        check("rst_count", 32'(draw_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_exh", 32'(exhausted), 32'd0);
        check("rst_strobe", 32'(next_edge), 32'd0);
        @(negedge clk); rst = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (next_edge) strobes++;
        end
        check("idle_strobes", 32'(strobes), 32'd0);
        check("idle_guess", 32'(guessed_number), 32'd0);
        check("idle_count", 32'(draw_count), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Four draws: start points 1, 2, 4, then 4 again which must wrap to 3
        arm("d1", 8'd1); run_draw("d1", 1'b0, num, lat);
        check("d1_val", 32'(num), 32'd1); check("d1_minlat", 32'(lat), 32'd2);
        arm("d2", 8'd2); run_draw("d2", 1'b0, num, lat);
        check("d2_val", 32'(num), 32'd2);
        check("d2_count", 32'(draw_count), 32'd2);
        check("d2_exh", 32'(exhausted), 32'd0);
        arm("d3", 8'd4); run_draw("d3", 1'b0, num, lat);
        check("d3_val", 32'(num), 32'd4);
        arm("d4", 8'd4); run_draw("d4", 1'b0, num, lat);
        check("wrap_val", 32'(num), 32'd3); check("wrap_lat", 32'(lat), 32'd5);
        check("full_count", 32'(draw_count), 32'd4);
        check("full_exh", 32'(exhausted), 32'd1);

        // Fifth request after exhaustion is ignored
        arm("d5", 8'd1);
        strobes = 0; busies = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (next_edge) strobes++;
            if (busy) busies++;
        end
        check("exh_strobes", 32'(strobes), 32'd0);
        check("exh_busy", 32'(busies), 32'd0);
        check("exh_count", 32'(draw_count), 32'd4);
        draw_req = 1'b0;

        // new_game from IDLE clears history but keeps the shown number
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
        clear_model();
        check("ng_count", 32'(draw_count), 32'd0);
        check("ng_exh", 32'(exhausted), 32'd0);
        check("ng_guess", 32'(guessed_number), 32'd3);

        // Request edge coinciding with new_game is dropped
        arm("ngedge", 8'd2);
        new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
        busies = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (busy || next_edge) busies++;
        end
        check("ngedge_drop", 32'(busies), 32'd0);

        // new_game while probing past an already-used slot aborts silently
        arm("pre", 8'd1); run_draw("pre", 1'b0, num, lat);
        check("pre_val", 32'(num), 32'd1);
        arm("abort", 8'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd1);
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_count", 32'(draw_count), 32'd0);
        check("abort_exh", 32'(exhausted), 32'd0);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            if (next_edge) strobes++;
            @(posedge clk); #1;
        end
        check("abort_strobes", 32'(strobes), 32'd0);
        clear_model();
        arm("post", 8'd2); run_draw("post", 1'b0, num, lat);
        check("post_val", 32'(num), 32'd2);
        check("post_count", 32'(draw_count), 32'd1);

        // halt blocks a new request
        halt = 1'b1;
        arm("halt", 8'd3);
        busies = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (busy || next_edge) busies++;
        end
        check("halt_block", 32'(busies), 32'd0);
        check("halt_count", 32'(draw_count), 32'd1);
        halt = 1'b0;

        // halt rising during SEED does not abort the draw
        arm("hseed", 8'd200); run_draw("hseed", 1'b1, num, lat);
        check("hseed_count", 32'(draw_count), 32'd2);
        halt = 1'b0;

        // draw_req held high for 100 cycles yields a single draw
        arm("hold", 8'd150); run_draw("hold", 1'b0, num, lat);
        strobes = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (next_edge) strobes++;
        end
        check("hold_extra", 32'(strobes), 32'd0);
        check("hold_count", 32'(draw_count), 32'd3);
        draw_req = 1'b0;

        // Asynchronous reset in the middle of a draw
        arm("mrst", 8'd4);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_count", 32'(draw_count), 32'd0);
        check("mrst_guess", 32'(guessed_number), 32'd0);
        check("mrst_strobe", 32'(next_edge), 32'd0);
        draw_req = 1'b0;
        clear_model();
        @(negedge clk); rst = 1'b0;
        arm("after", 8'd3); run_draw("after", 1'b0, num, lat);
        check("after_val", 32'(num), 32'd3);
        check("after_count", 32'(draw_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
